rv32_instr_stream_gen: RTL

//  Synthesisable, seeded random RV32I instruction-stream source for sodor5 differential traces.

---
 rtl/rv32_gen_pkg.sv | 32 +++
 rtl/lfsr32_galois.sv | 33 +++
 rtl/rv32_instr_stream_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rv32_gen_pkg.sv
// Shared constants, enums and LFSR helpers for the RV32I random instruction-stream generator.
package rv32_gen_pkg;

    localparam logic [6:0]  OPC_OPIMM  = 7'h13;
    localparam logic [6:0]  OPC_LOAD   = 7'h03;
    localparam logic [6:0]  OPC_STORE  = 7'h23;
    localparam logic [6:0]  OPC_OP     = 7'h33;
    localparam logic [31:0] NOP        = 32'h00000013;
    localparam logic [31:0] LFSR_TAPS  = 32'h80200003;
    localparam logic [31:0] SEED_B_XOR = 32'hA5A5A5A5;

    // Code 3 is shared by OP and the NOP/warm-up marker; the opcode tells them apart.
    typedef enum logic [1:0] {
        CLS_OPIMM = 2'd0,
        CLS_LOAD  = 2'd1,
        CLS_STORE = 2'd2,
        CLS_OP    = 2'd3
    } instr_class_t;

    localparam logic [1:0] CLS_NOP = 2'd3;

    typedef enum logic [1:0] {IDLE, WARMUP, GEN, DONE} gen_state_t;

    function automatic logic [31:0] lfsr_fix(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'd0);
    endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR with seed load; a zero seed is replaced by 1 so it can never lock up.
module lfsr32_galois
    import rv32_gen_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'd1,
    parameter int          OUT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [31:0]      load_val,
    input  logic             step,
    output logic [OUT_W-1:0] state
);

    logic [31:0] lfsr_reg;
    logic [31:0] base;

    // A load and a step in the same cycle step from the freshly loaded value.
    assign base  = load ? lfsr_fix(load_val) : lfsr_reg;
    assign state = lfsr_reg[OUT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= lfsr_fix(RESET_VAL);
        end else if (step) begin
            lfsr_reg <= lfsr_step(base);
        end else if (load) begin
            lfsr_reg <= base;
        end
    end

endmodule

// File: rtl/rv32_instr_stream_gen.sv
// Seeded random RV32I instruction source (OP-IMM/LOAD/STORE/OP) with warm-up NOPs,
// valid/ready handshake and a bounded instruction count.
module rv32_instr_stream_gen
    import rv32_gen_pkg::*;
#(
    parameter logic [31:0] SEED        = 32'd264,
    parameter int          WARMUP_NOPS = 4,
    parameter logic [4:0]  REG_MASK    = 5'h1F,
    parameter logic [11:0] LD_IMM_MASK = 12'h03C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        seed_load,
    input  logic [31:0] seed_i,
    input  logic [3:0]  class_en,
    input  logic [15:0] num_instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [1:0]  instr_class,
    output logic        busy,
    output logic        done,
    output logic [15:0] count
);

    localparam logic [15:0] WARM_LAST = 16'(WARMUP_NOPS - 1);

    gen_state_t  state, state_next;
    logic [15:0] warm_cnt;
    logic        hs, seed_ld, start_ok, warm_last, gen_last, advance;
    logic [31:0] a_state, a_cur, seed_b;
    logic [15:0] b_state, b_cur;
    logic [31:0] gen_word;
    logic [1:0]  gen_class, pick, sel;

    assign hs        = instr_valid & instr_ready;
    assign seed_ld   = (state == IDLE) & seed_load;
    assign start_ok  = start & ((state == IDLE) | (state == DONE));
    assign warm_last = (WARMUP_NOPS == 0) || (warm_cnt == WARM_LAST);
    assign gen_last  = (num_instr != 16'd0) && ((count + 16'd1) == num_instr);
    assign advance   = ((state_next == GEN) && (state != GEN)) ||
                       ((state == GEN) && hs && !gen_last);

    // The encoder sees a seed being loaded this cycle, so load+start starts from the new seed.
    assign seed_b = seed_i ^ SEED_B_XOR;
    assign a_cur  = seed_ld ? lfsr_fix(seed_i) : a_state;
    assign b_cur  = seed_ld ? ((seed_b == 32'd0) ? 16'd1 : seed_b[15:0]) : b_state;

    lfsr32_galois #(.RESET_VAL(SEED), .OUT_W(32)) u_lfsr_a (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_ld),
        .load_val (seed_i),
        .step     (advance),
        .state    (a_state)
    );

    lfsr32_galois #(.RESET_VAL(SEED ^ SEED_B_XOR), .OUT_W(16)) u_lfsr_b (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_ld),
        .load_val (seed_b),
        .step     (advance),
        .state    (b_state)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = (WARMUP_NOPS == 0) ? GEN : WARMUP;
            WARMUP:     if (hs && warm_last) state_next = GEN;
            GEN:        if (hs && gen_last) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        instr_valid = (state == WARMUP) || (state == GEN);
        busy        = (state == WARMUP) || (state == GEN);
        done        = (state == DONE);
    end

    // Disabled picks rotate forward to the nearest enabled class.
    assign pick = a_cur[31:30];
    always_comb begin
        sel = pick;
        for (int k = 3; k >= 0; k--) begin
            if (class_en[pick + 2'(k)]) sel = pick + 2'(k);
        end
    end

    logic [11:0] imm, imm_sh, imml;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3, f3l, ld_f3, st_f3;
    logic [6:0]  f7;

    assign imm  = a_cur[11:0];
    assign rs1  = a_cur[16:12] & REG_MASK;
    assign rs2  = a_cur[21:17] & REG_MASK;
    assign rd   = a_cur[26:22] & REG_MASK;
    assign f3   = a_cur[29:27];
    assign f3l  = b_cur[2:0];
    assign imml = b_cur[14:3] & LD_IMM_MASK;

    always_comb begin
        imm_sh = (f3 == 3'd1) ? (imm & 12'h01F) : (f3 == 3'd5) ? (imm & 12'h41F) : imm;
        case (f3l)
            3'd0, 3'd5: ld_f3 = 3'd0;
            3'd1, 3'd6: ld_f3 = 3'd1;
            3'd2, 3'd7: ld_f3 = 3'd2;
            3'd3:       ld_f3 = 3'd4;
            default:    ld_f3 = 3'd5;
        endcase
        case (f3l)
            3'd0, 3'd3, 3'd6: st_f3 = 3'd0;
            3'd1, 3'd4, 3'd7: st_f3 = 3'd1;
            default:          st_f3 = 3'd2;
        endcase
        f7 = (b_cur[15] && ((f3 == 3'd0) || (f3 == 3'd5))) ? 7'h20 : 7'h00;

        gen_word  = NOP;
        gen_class = CLS_NOP;
        if (class_en != 4'd0) begin
            gen_class = sel;
            case (sel)
                CLS_OPIMM: gen_word = {imm_sh, rs1, f3, rd, OPC_OPIMM};
                CLS_LOAD:  gen_word = {imml, rs1, ld_f3, rd, OPC_LOAD};
                CLS_STORE: gen_word = {imml[11:5], rs2, rs1, st_f3, imml[4:0], OPC_STORE};
                default:   gen_word = {f7, rs2, rs1, f3, rd, OPC_OP};
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr       <= NOP;
            instr_class <= CLS_NOP;
            count       <= 16'd0;
            warm_cnt    <= 16'd0;
        end else begin
            if (start_ok) begin
                count    <= 16'd0;
                warm_cnt <= 16'd0;
            end else begin
                if ((state == WARMUP) && hs) warm_cnt <= warm_cnt + 16'd1;
                if ((state == GEN) && hs) count <= count + 16'd1;
            end
            if (advance) begin
                instr       <= gen_word;
                instr_class <= gen_class;
            end else if (start_ok || ((state == GEN) && hs)) begin
                instr       <= NOP;
                instr_class <= CLS_NOP;
            end
        end
    end

endmodule
